// File: rtl/rom_reader_pkg.sv
// Shared types and defaults for the ROM bring-up reader: FSM encoding,
// checksum width and the default geometry of the ROM macro.
package rom_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int SUM_W      = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LAT    = 2;

endpackage

// File: rtl/rom_scan_reader_if.sv
// Read bus between the scan reader (master) and the ROM macro (slave).
interface rom_scan_reader_if
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_en, output rom_addr, input rom_data);
    modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/rom_scan_reader_sync_edge.sv
// Two-flop synchroniser for an asynchronous pad strobe followed by a
// single-cycle rising-edge pulse in the clk domain.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/rom_scan_reader.sv
// ROM read initiator: single-address read or full-array scan with a 16-bit
// additive checksum, paced by a fixed ROM access latency.
module rom_scan_reader
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LAT    = DEF_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [ADDR_W-1:0]      addr_in,
    rom_scan_reader_if.master      rom,
    output logic [DATA_W-1:0]      data_out,
    output logic [SUM_W-1:0]       sum_out,
    output logic                   busy,
    output logic                   done
);
    localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

    function automatic logic [SUM_W-1:0] add_wrap(input logic [SUM_W-1:0] acc,
                                                  input logic [DATA_W-1:0] word);
        return acc + SUM_W'(word);
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              start_edge;

    sync_edge u_start_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (start),
        .rise_o  (start_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                // Edges outside IDLE are simply never looked at, so they drop.
                if (start_edge) begin
                    mode_d  = mode;
                    state_d = ST_READ;
                    if (mode) begin
                        addr_d = '0;
                        sum_d  = '0;
                    end else begin
                        addr_d = addr_in;
                    end
                end
            end
            ST_READ: begin
                cnt_d   = LAT_M1;
                state_d = (LAT > 1) ? ST_WAIT : ST_CAPTURE;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                data_d = rom.rom_data;
                if (mode_q) sum_d = add_wrap(sum_q, rom.rom_data);
                // The scan stops on the last address instead of wrapping to 0.
                if (!mode_q || (addr_q == '1)) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign rom.rom_en   = (state_q == ST_READ);
    assign rom.rom_addr = addr_q;
    assign data_out     = data_q;
    assign sum_out      = sum_q;
    assign busy         = (state_q == ST_READ) || (state_q == ST_WAIT) ||
                          (state_q == ST_CAPTURE);
    assign done         = (state_q == ST_DONE);
endmodule

// File: tb/tb_rom_scan_reader.sv
// Directed bench for rom_scan_reader: a LAT=2 instance for the main scenarios
// and a LAT=1 instance for the reset-during-scan scenario.
module tb_rom_scan_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // LAT=2 instance
    logic        rst_n, start2, mode2;
    logic [7:0]  addr2, data2;
    logic [15:0] sum2;
    logic        busy2, done2;
    int          kind2 = 0;
    logic [7:0]  p0, p1;
    rom_scan_reader_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

    rom_scan_reader #(.ADDR_W(8), .DATA_W(8), .LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .addr_in(addr2),
        .rom(bus2.master), .data_out(data2), .sum_out(sum2), .busy(busy2), .done(done2)
    );

    // LAT=1 instance
    logic        rst1_n, start1, mode1;
    logic [7:0]  addr1, data1;
    logic [15:0] sum1;
    logic        busy1, done1;
    int          kind1 = 1;
    logic [7:0]  q0;
    rom_scan_reader_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

    rom_scan_reader #(.ADDR_W(8), .DATA_W(8), .LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .mode(mode1), .addr_in(addr1),
        .rom(bus1.master), .data_out(data1), .sum_out(sum1), .busy(busy1), .done(done1)
    );

    function automatic logic [7:0] rom_f(input int kind, input logic [7:0] a);
        case (kind)
            0:       return a ^ 8'hA5;
            1:       return a;
            default: return 8'hFF;
        endcase
    endfunction

    // ROM models: data valid LAT cycles after rom_en, junk on all other cycles
    always @(posedge clk) begin
        p0 <= bus2.rom_en ? rom_f(kind2, bus2.rom_addr) : 8'h3C;
        p1 <= p0;
        q0 <= bus1.rom_en ? rom_f(kind1, bus1.rom_addr) : 8'hC3;
    end
    assign bus2.rom_data = p1;
    assign bus1.rom_data = q0;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one operation on the LAT=2 instance and observes the ROM bus.
    task automatic run_op(input logic m, input logic [7:0] a, input int inject_at, input int maxcyc,
                          output int en_cnt, output int seq_err, output int done_cnt,
                          output int done_dly, output logic [7:0] d_at, output logic [15:0] s_at,
                          output logic busy_at);
        int c0, last_en, stop_at, start_off, inj_off;
        en_cnt = 0; seq_err = 0; done_cnt = 0; done_dly = -1;
        d_at = 8'h00; s_at = 16'h0000; busy_at = 1'b1; last_en = 0; inj_off = -1;
        @(negedge clk);
        mode2 = m; addr2 = a; start2 = 1'b1;
        c0 = cyc; start_off = c0 + 4; stop_at = c0 + maxcyc;
        while (cyc < stop_at) begin
            @(negedge clk);
            if (cyc == start_off) start2 = 1'b0;
            if (inj_off >= 0 && cyc == inj_off) start2 = 1'b0;
            if (bus2.rom_en) begin
                if (bus2.rom_addr !== (m ? 8'(en_cnt) : a)) seq_err++;
                if (en_cnt > 0 && (cyc - last_en) != 3) seq_err++;
                if (!busy2) seq_err++;
                last_en = cyc;
                en_cnt++;
                if (inject_at >= 0 && en_cnt == inject_at + 1) begin
                    start2 = 1'b1;
                    inj_off = cyc + 4;
                end
            end
            if (done2) begin
                if (done_cnt == 0) begin
                    done_dly = cyc - c0;
                    d_at = data2; s_at = sum2; busy_at = busy2;
                    stop_at = cyc + 12;
                end
                done_cnt++;
            end
        end
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst1_n = 1'b0;
        start2 = 1'b0; mode2 = 1'b0; addr2 = 8'h00;
        start1 = 1'b0; mode1 = 1'b0; addr1 = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);
        checks++; if (bus2.rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got %b want 0", bus2.rom_en); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy2); end
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done2); end
        checks++; if (data2 !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data2); end
        checks++; if (sum2 !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h want 0000", sum2); end
        checks++; if (bus2.rom_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", bus2.rom_addr); end
        checks++; if (sum1 !== 16'h0000 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_lat1 got sum %h busy %b want 0000 0", sum1, busy1); end
    endtask

    task automatic test_single_read(input logic [7:0] a, input logic [7:0] exp_d, input logic [15:0] exp_s);
        int en, se, dc, dd; logic [7:0] d; logic [15:0] s; logic b;
        kind2 = 0;
        run_op(1'b0, a, -1, 100, en, se, dc, dd, d, s, b);
        checks++; if (en !== 1) begin errors++; $display("FAIL single_en_count got %0d want 1", en); end
        checks++; if (se !== 0) begin errors++; $display("FAIL single_bus got %0d errs want 0", se); end
        checks++; if (dd !== 6) begin errors++; $display("FAIL single_latency got %0d want 6", dd); end
        checks++; if (d !== exp_d) begin errors++; $display("FAIL single_data got %h want %h", d, exp_d); end
        checks++; if (s !== exp_s) begin errors++; $display("FAIL single_sum got %h want %h", s, exp_s); end
        checks++; if (b !== 1'b0) begin errors++; $display("FAIL single_busy_at_done got %b want 0", b); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL single_done_count got %0d want 1", dc); end
    endtask

    task automatic test_scan(input int kind, input int inject_at, input logic [15:0] exp_s);
        int en, se, dc, dd; logic [7:0] d; logic [15:0] s; logic b;
        kind2 = kind;
        run_op(1'b1, 8'h00, inject_at, 1000, en, se, dc, dd, d, s, b);
        checks++; if (en !== 256) begin errors++; $display("FAIL scan_en_count got %0d want 256", en); end
        checks++; if (se !== 0) begin errors++; $display("FAIL scan_bus got %0d errs want 0", se); end
        checks++; if (dd - 2 !== 769) begin errors++; $display("FAIL scan_latency got %0d want 769", dd - 2); end
        checks++; if (s !== exp_s) begin errors++; $display("FAIL scan_sum got %h want %h", s, exp_s); end
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL scan_data got %h want ff", d); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL scan_done_count got %0d want 1", dc); end
        checks++; if (bus2.rom_addr !== 8'hFF || sum2 !== exp_s) begin
            errors++; $display("FAIL scan_hold got addr %h sum %h want ff %h", bus2.rom_addr, sum2, exp_s);
        end
    endtask

    task automatic test_reset_mid_scan();
        int c0; bit found;
        kind1 = 1; found = 0;
        @(negedge clk);
        mode1 = 1'b1; start1 = 1'b1; c0 = cyc;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (cyc == c0 + 4) start1 = 1'b0;
            if (bus1.rom_en && bus1.rom_addr == 8'h80) begin found = 1; break; end
        end
        start1 = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL midscan_reach got no rom_en at 80 want seen"); end
        #2 rst1_n = 1'b0;
        #1;
        checks++; if (bus1.rom_en !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++; $display("FAIL midscan_ctrl got en %b busy %b done %b want 0 0 0", bus1.rom_en, busy1, done1);
        end
        checks++; if (sum1 !== 16'h0000 || data1 !== 8'h00 || bus1.rom_addr !== 8'h00) begin
            errors++; $display("FAIL midscan_data got sum %h data %h addr %h want 0000 00 00", sum1, data1, bus1.rom_addr);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst1_n = 1'b1;
        @(negedge clk);
        mode1 = 1'b1; start1 = 1'b1; c0 = cyc; found = 0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (cyc == c0 + 4) start1 = 1'b0;
            if (done1) begin found = 1; break; end
        end
        start1 = 1'b0;
        checks++; if (!found || (cyc - c0) != 515) begin
            errors++; $display("FAIL rescan_latency got %0d want 515", found ? cyc - c0 : -1);
        end
        checks++; if (sum1 !== 16'h7F80) begin errors++; $display("FAIL rescan_sum got %h want 7f80", sum1); end
    endtask

    initial begin
        test_reset();
        test_single_read(8'h5A, 8'hFF, 16'h0000);
        test_scan(1, -1, 16'h7F80);
        test_single_read(8'h03, 8'hA6, 16'h7F80);
        test_scan(2, -1, 16'hFF00);
        test_scan(2, -1, 16'hFF00);
        test_scan(1, 8'h40, 16'h7F80);
        test_single_read(8'h10, 8'hB5, 16'h7F80);
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_scan_reader.md
Name: rom_scan_reader

Overview:
- Read-side initiator for the on-die ROM macro under test. It drives address and enable into the ROM and waits a fixed access latency, then captures each data word.
- Two operations: single-address read, or full-array scan that accumulates a 16-bit additive checksum for silicon bring-up.
- Sits between the tile's user pins (start and address from ui_in/uio_in) and the ROM macro. Results go back to uo_out.

Parameters:
- ADDR_W, 8, ROM address width; scan covers 0 .. 2^ADDR_W-1.
- DATA_W, 8, ROM data width.
- LAT, 2, ROM read latency in clocks from the rom_en cycle to valid rom_data; legal range 1..7.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe from a pad, asynchronous to clk; synchronised internally.
- mode  in  1  0 = single read at addr_in, 1 = full scan; sampled on the detected start edge.
- addr_in  in  ADDR_W  single-read address; sampled on the detected start edge.
- rom_en  out  1  ROM read enable; high exactly one cycle per access.
- rom_addr  out  ADDR_W  ROM address; held stable from its rom_en cycle until the capture cycle.
- rom_data  in  DATA_W  ROM read data; valid LAT cycles after rom_en.
- data_out  out  DATA_W  last captured word.
- sum_out  out  16  running checksum.
- busy  out  1  high from the READ state through the final CAPTURE.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - rom_en=0, rom_addr=0, data_out=0, sum_out=0, busy=0, done=0.
  - Synchroniser flops and edge register are cleared.
- Start detection: start passes through a 2-flop synchroniser, then rising-edge detect. The edge is seen 2-3 clocks after the pad transition.
- An edge is ignored unless state is IDLE. Edges arriving while busy or in DONE are dropped, not queued.
- FSM states: IDLE, READ, WAIT, CAPTURE, DONE.
- IDLE:
  - rom_en=0.
  - On a start edge:
    - mode=0: rom_addr<=addr_in; sum_out is unchanged.
    - mode=1: rom_addr<=0 and sum_out<=0.
  - Latch mode internally and go to READ.
- READ: rom_en=1 for this cycle only, busy=1.
  - Load the wait counter with LAT-1.
  - Go to WAIT if LAT>1, else go to CAPTURE.
- WAIT: counter decrements each cycle; go to CAPTURE when it reaches 0. rom_en=0 and rom_addr is held.
- CAPTURE (exactly LAT cycles after the READ cycle): data_out<=rom_data.
  - Scan mode: sum_out<=sum_out+zero-extended rom_data, modulo 2^16. Single mode leaves sum_out untouched.
  - Single mode: go to DONE.
  - Scan mode with rom_addr = all-ones: go to DONE, leaving rom_addr at all-ones with no wrap.
  - Otherwise: rom_addr<=rom_addr+1 and go to READ.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE.
- Timing:
  - Per access: LAT+1 cycles.
  - Single read: detected edge -> done = LAT+2 cycles.
  - Full scan: 2^ADDR_W*(LAT+1)+1 cycles from detected edge to done (769 with defaults).
- Outputs hold their values in IDLE, so the last result stays readable on the pins.
- Reset mid-operation returns immediately to reset values; the partial sum is discarded.
- A rom_data change outside the CAPTURE cycle has no effect.

Decomposition:
- Package rom_reader_pkg holds:
  - the FSM state enum (3-bit encoding);
  - the checksum width constant SUM_W=16;
  - default ADDR_W/DATA_W/LAT values.
- One sub-module, sync_edge: a 2-flop synchroniser plus rising-edge pulse, with asynchronous active-low reset. It is reused for other pad strobes in the tile.

Test Plan:
- Reset defaults: hold rst_n=0 for 5 clocks, then release -> rom_en=0, busy=0, done=0, data_out=0x00, sum_out=0x0000.
- Single read: ROM model returns data = addr ^ 0xA5, with LAT=2. Send mode=0, addr_in=0x5A and pulse start.
  - rom_en high one cycle with rom_addr=0x5A.
  - data_out=0xFF captured 2 cycles later.
  - done pulse; sum_out unchanged.
- Full scan, ROM data = addr: mode=1 -> rom_en pulses 256 times at addresses 0x00..0xFF, each 3 cycles apart.
  - sum_out=0x7F80 and data_out=0xFF at done.
  - done occurs 769 cycles after the detected edge.
- Checksum wrap, ROM all 0xFF: scan -> sum_out=0xFF00. Run a second scan -> sum_out restarts from 0 and is again 0xFF00.
- Start while busy: issue a second start edge mid-scan (around address 0x40) -> scan is unaffected and only one done pulse occurs. A start after done begins a new operation.
- Reset mid-scan, LAT=1 build: assert rst_n low at address 0x80 -> outputs return to reset values asynchronously. A fresh scan after release completes with the correct sum.
